// File: rtl/cache_pkg.sv
// Shared types and constants for the data-cache sequencing controller.
package cache_pkg;

  localparam int LINE_BYTES  = 4;
  localparam int OFFSET_BITS = 2;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    REFILL
  } ctrl_state_t;

  typedef logic [LINE_BYTES-1:0][7:0] line_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cache_controller.sv
// Sequencing FSM for the direct-mapped write-back data cache (hit check, writeback, refill).
// Optional hit/miss/writeback counters are built when CACHE_CTRL_STATS_EN is defined.
//
// state     | meaning
// IDLE      | waiting for cpu_req; request fields latched on acceptance
// COMPARE   | tag check; hit completes the request, miss picks writeback or refill
// WRITEBACK | dirty victim line being written to memory
// REFILL    | requested line being read from memory into the cache
module cache_controller
  import cache_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [XLEN-1:0]           cpu_addr,
  input  logic [LINE_BYTES*8-1:0]   cpu_wdata,
  output logic [LINE_BYTES*8-1:0]   cpu_rdata,
  output logic                      cpu_ready,
  output logic                      cpu_busy,
  output logic [XLEN-1:0]           cache_addr,
  output logic [LINE_BYTES*8-1:0]   cache_din,
  output logic                      cache_we,
  input  logic [LINE_BYTES*8-1:0]   cache_dout,
  input  logic                      cache_hit,
  input  logic                      cache_dirty,
  input  logic [XLEN-1:0]           cache_miss_addr,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [XLEN-1:0]           mem_addr,
  output logic [LINE_BYTES*8-1:0]   mem_wdata,
  input  logic [LINE_BYTES*8-1:0]   mem_rdata,
  input  logic                      mem_ready
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]               hit_cnt,
  output logic [31:0]               miss_cnt,
  output logic [31:0]               wb_cnt
`endif
);

  localparam logic [XLEN-1:0] LINE_MASK = ~XLEN'((1 << OFFSET_BITS) - 1);

  ctrl_state_t     state, state_nxt;
  logic [XLEN-1:0] addr_q;
  logic            we_q;
  line_t           wdata_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cpu_req) begin
        addr_q  <= cpu_addr;
        we_q    <= cpu_we;
        wdata_q <= cpu_wdata;
      end
      // Memory outputs are loaded from the next state so they are stable for the whole wait.
      mem_req <= (state_nxt == WRITEBACK) || (state_nxt == REFILL);
      mem_we  <= (state_nxt == WRITEBACK);
      if (state == COMPARE && state_nxt == WRITEBACK) begin
        mem_addr  <= cache_miss_addr & LINE_MASK;
        mem_wdata <= cache_dout;
      end else if (state != REFILL && state_nxt == REFILL) begin
        mem_addr <= addr_q & LINE_MASK;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cpu_ready = 1'b0;
    cache_we  = 1'b0;
    cache_din = wdata_q;
    case (state)
      IDLE: begin
        if (cpu_req) state_nxt = COMPARE;
      end
      COMPARE: begin
        if (cache_hit) begin
          cpu_ready = 1'b1;
          cache_we  = we_q;
          state_nxt = IDLE;
        end else if (cache_dirty) begin
          state_nxt = WRITEBACK;
        end else begin
          state_nxt = REFILL;
        end
      end
      WRITEBACK: begin
        if (mem_ready) state_nxt = REFILL;
      end
      REFILL: begin
        cache_din = mem_rdata;
        if (mem_ready) begin
          cache_we  = 1'b1;
          state_nxt = COMPARE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_busy   = (state != IDLE);
  assign cpu_rdata  = cache_dout;
  assign cache_addr = addr_q;

`ifdef CACHE_CTRL_STATS_EN
  generate
    begin : g_stats
      // Set only on the COMPARE entered from IDLE, so the post-refill hit is not counted.
      logic first_cmp;

      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          first_cmp <= 1'b0;
          hit_cnt   <= '0;
          miss_cnt  <= '0;
          wb_cnt    <= '0;
        end else begin
          first_cmp <= (state == IDLE);
          if (state == COMPARE && first_cmp && cache_hit)  hit_cnt  <= sat_inc(hit_cnt);
          if (state == COMPARE && first_cmp && !cache_hit) miss_cnt <= sat_inc(miss_cnt);
          if (state == WRITEBACK && mem_ready)             wb_cnt   <= sat_inc(wb_cnt);
        end
      end
    end
  endgenerate
`endif

endmodule
